// File: rtl/clangpu_pkg.sv
// Shared definitions for the clangpu memory-side blocks: fixed AXI4 encodings,
// the store request record and the store FSM state encoding.
package clangpu_pkg;

  // AXI4 burst and attribute encodings used by single-beat 32-bit writes.
  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  // AXI4 write response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One queued store request as seen on the core side.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } store_req_t;

  localparam int STORE_REQ_W = $bits(store_req_t);

  // Store write engine: one outstanding AXI write at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } store_state_t;

endpackage

// File: rtl/store_queue.sv
// Synchronous FIFO holding pending store requests. The head entry is visible
// combinationally; a push while full is ignored. The full flag is a register
// so a pop in the same cycle does not release back-pressure until the next one.
module store_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned, which would infer a latch.
    count_next = count_q;
    case ({do_push, do_pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Pointers, occupancy and registered full flag; pointers wrap naturally.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      full_q  <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Entry storage, written at the tail.
  // NOTE: the array has no reset; the pointers and count alone decide which
  // entries are meaningful, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/store.sv
// Store unit: buffers core store requests in a small queue and issues each as
// a single-beat AXI4 write, one outstanding at a time, reporting BRESP back to
// the core with a one-cycle completion pulse.
module store
  import clangpu_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_AWUSER_WIDTH    = 1,
  parameter int C_M_AXI_WUSER_WIDTH     = 4,
  parameter int C_M_AXI_BUSER_WIDTH     = 1,
  parameter int QUEUE_DEPTH             = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,

  // Core request side
  input  logic                                 I_VALID,
  input  logic [31:0]                          I_ADDR,
  input  logic [31:0]                          I_DATA,
  input  logic [3:0]                           I_STRB,
  output logic                                 MEM_WAIT,
  output logic                                 O_VALID,
  output logic [1:0]                           O_RESP,

  // AXI write address channel
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
  output logic [7:0]                           M_AXI_AWLEN,
  output logic [2:0]                           M_AXI_AWSIZE,
  output logic [1:0]                           M_AXI_AWBURST,
  output logic                                 M_AXI_AWLOCK,
  output logic [3:0]                           M_AXI_AWCACHE,
  output logic [2:0]                           M_AXI_AWPROT,
  output logic [3:0]                           M_AXI_AWQOS,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]      M_AXI_AWUSER,
  output logic                                 M_AXI_AWVALID,
  input  logic                                 M_AXI_AWREADY,

  // AXI write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
  output logic                                 M_AXI_WLAST,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]       M_AXI_WUSER,
  output logic                                 M_AXI_WVALID,
  input  logic                                 M_AXI_WREADY,

  // AXI write response channel
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_BID,
  input  logic [1:0]                           M_AXI_BRESP,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]       M_AXI_BUSER,
  input  logic                                 M_AXI_BVALID,
  output logic                                 M_AXI_BREADY
);

  localparam int Q_CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int STRB_W  = C_M_AXI_DATA_WIDTH / 8;

  store_state_t         state_q;
  store_state_t         state_next;
  store_req_t           push_req;
  store_req_t           head_req;
  logic [Q_CNT_W-1:0]   q_count;
  logic                 q_full;

  logic                 pop;
  logic                 aw_done;
  logic                 w_done;
  logic                 bready;
  logic                 b_fire;

  logic                 awvalid_q;
  logic                 wvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic                 o_valid_q;
  logic [1:0]           o_resp_q;

  // Response ID and user bits carry nothing this unit needs.
  logic                 unused_b;
  assign unused_b = ^{M_AXI_BID, M_AXI_BUSER};

  assign push_req = '{addr: I_ADDR, data: I_DATA, strb: I_STRB};

  store_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (STORE_REQ_W)
  ) u_queue (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .push      (I_VALID),
    .push_data (push_req),
    .pop       (pop),
    .head      (head_req),
    .full      (q_full),
    .count     (q_count)
  );

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_next;
  end

  // FSM next-state: leave SEND only once both address and data have handshaken.
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      ST_IDLE: if (pop)                state_next = ST_SEND;
      ST_SEND: if (aw_done && w_done)  state_next = ST_RESP;
      ST_RESP: if (b_fire)             state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: a channel counts as done if it already handshook or does so now.
  always_comb begin
    pop     = (state_q == ST_IDLE) && (q_count != '0);
    aw_done = !awvalid_q || M_AXI_AWREADY;
    w_done  = !wvalid_q  || M_AXI_WREADY;
    bready  = (state_q == ST_RESP);
    b_fire  = bready && M_AXI_BVALID;
  end

  // AW/W channel registers and completion report; VALIDs are pure registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    // NOTE: state elements are updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!ARESETN) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      o_valid_q <= 1'b0;
      o_resp_q  <= RESP_OKAY;
    end else begin
      if (pop) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= C_M_AXI_ADDR_WIDTH'(head_req.addr);
        wdata_q   <= C_M_AXI_DATA_WIDTH'(head_req.data);
        wstrb_q   <= STRB_W'(head_req.strb);
      end else begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
      end
      o_valid_q <= b_fire;
      if (b_fire) o_resp_q <= M_AXI_BRESP;
    end
  end

  assign MEM_WAIT      = q_full;
  assign O_VALID       = o_valid_q;
  assign O_RESP        = o_resp_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = SIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_BUF_MOD;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = awvalid_q;

  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = wvalid_q;

  assign M_AXI_BREADY  = bready;

endmodule

// File: tb/tb_store.sv
// Directed bench for the store unit with a simple AXI slave driven by hand
// and a monitor logging accepted AW/W beats and completion pulses.
module tb_store;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        I_VALID;
  logic [31:0] I_ADDR;
  logic [31:0] I_DATA;
  logic [3:0]  I_STRB;
  logic        MEM_WAIT;
  logic        O_VALID;
  logic [1:0]  O_RESP;

  logic        M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic        M_AXI_AWUSER;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic [3:0]  M_AXI_WUSER;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic        M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BUSER;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  always #5 ACLK = ~ACLK;

  store #(.QUEUE_DEPTH(4)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .I_VALID       (I_VALID),
    .I_ADDR        (I_ADDR),
    .I_DATA        (I_DATA),
    .I_STRB        (I_STRB),
    .MEM_WAIT      (MEM_WAIT),
    .O_VALID       (O_VALID),
    .O_RESP        (O_RESP),
    .M_AXI_AWID    (M_AXI_AWID),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWLEN   (M_AXI_AWLEN),
    .M_AXI_AWSIZE  (M_AXI_AWSIZE),
    .M_AXI_AWBURST (M_AXI_AWBURST),
    .M_AXI_AWLOCK  (M_AXI_AWLOCK),
    .M_AXI_AWCACHE (M_AXI_AWCACHE),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWQOS   (M_AXI_AWQOS),
    .M_AXI_AWUSER  (M_AXI_AWUSER),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WLAST   (M_AXI_WLAST),
    .M_AXI_WUSER   (M_AXI_WUSER),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BID     (M_AXI_BID),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BUSER   (M_AXI_BUSER),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor: accepted beats, completion pulses, AW stability while stalled.
  logic [31:0] aw_log[$];
  logic [31:0] wd_log[$];
  logic [3:0]  ws_log[$];
  int          ov_cnt   = 0;
  int          stab_err = 0;
  logic        aw_stall = 1'b0;
  logic [31:0] aw_prev  = '0;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_stall <= 1'b0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_log.push_back(M_AXI_AWADDR);
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        wd_log.push_back(M_AXI_WDATA);
        ws_log.push_back(M_AXI_WSTRB);
      end
      if (O_VALID) ov_cnt <= ov_cnt + 1;
      if (aw_stall && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_prev)) stab_err <= stab_err + 1;
      aw_stall <= M_AXI_AWVALID && !M_AXI_AWREADY;
      aw_prev  <= M_AXI_AWADDR;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_logs();
    aw_log.delete();
    wd_log.delete();
    ws_log.delete();
    ov_cnt = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    I_VALID = 1'b1;
    I_ADDR  = a;
    I_DATA  = d;
    I_STRB  = s;
    tick();
    I_VALID = 1'b0;
  endtask

  function automatic logic [31:0] aw_at(input int i);
    return (i < aw_log.size()) ? aw_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    return (i < wd_log.size()) ? wd_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [3:0] ws_at(input int i);
    return (i < ws_log.size()) ? ws_log[i] : 4'h0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_addr [5];
    logic [31:0] exp_data [5];
    logic [3:0]  exp_strb [5];
    int budget;

    ARESETN       = 1'b0;
    I_VALID       = 1'b0;
    I_ADDR        = '0;
    I_DATA        = '0;
    I_STRB        = '0;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    M_AXI_BVALID  = 1'b1;
    M_AXI_BRESP   = 2'b00;
    M_AXI_BID     = 1'b0;
    M_AXI_BUSER   = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid",  M_AXI_WVALID,  0);
    check("rst_bready",  M_AXI_BREADY,  0);
    check("rst_ovalid",  O_VALID,       0);
    check("rst_oresp",   O_RESP,        0);
    check("rst_memwait", MEM_WAIT,      0);
    check("rst_awaddr",  M_AXI_AWADDR,  0);
    check("rst_wdata",   M_AXI_WDATA,   0);
    check("rst_wstrb",   M_AXI_WSTRB,   0);
    ARESETN = 1'b1;
    tick();

    // Single write, all slave handshakes immediate
    clear_logs();
    push(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    tick();
    check("t1_awvalid", M_AXI_AWVALID, 1);
    check("t1_wvalid",  M_AXI_WVALID,  1);
    check("t1_awaddr",  M_AXI_AWADDR,  32'h0000_1000);
    check("t1_wdata",   M_AXI_WDATA,   32'hDEAD_BEEF);
    check("t1_wstrb",   M_AXI_WSTRB,   4'hF);
    check("t1_wlast",   M_AXI_WLAST,   1);
    check("t1_awsize",  M_AXI_AWSIZE,  3'b010);
    check("t1_awburst", M_AXI_AWBURST, 2'b01);
    check("t1_awcache", M_AXI_AWCACHE, 4'b0011);
    check("t1_awlen",   M_AXI_AWLEN,   0);
    check("t1_bready0", M_AXI_BREADY,  0);
    tick();
    check("t1_awdrop",  M_AXI_AWVALID, 0);
    check("t1_wdrop",   M_AXI_WVALID,  0);
    check("t1_bready1", M_AXI_BREADY,  1);
    check("t1_ov_early", O_VALID,      0);
    tick();
    check("t1_ovalid",  O_VALID,       1);
    check("t1_oresp",   O_RESP,        0);
    check("t1_bready_off", M_AXI_BREADY, 0);
    tick();
    check("t1_ov_pulse", O_VALID,      0);
    check("t1_ov_count", ov_cnt,       1);

    // AWREADY held low five cycles, WREADY high
    clear_logs();
    M_AXI_AWREADY = 1'b0;
    push(32'h2000_0004, 32'h1234_5678, 4'h3);
    tick();
    check("t2_awvalid", M_AXI_AWVALID, 1);
    check("t2_wvalid",  M_AXI_WVALID,  1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_aw_held",  M_AXI_AWVALID, 1);
      check("t2_aw_addr",  M_AXI_AWADDR,  32'h2000_0004);
      check("t2_w_dropped", M_AXI_WVALID, 0);
      check("t2_no_bready", M_AXI_BREADY, 0);
    end
    M_AXI_AWREADY = 1'b1;
    tick();
    check("t2_awdrop",  M_AXI_AWVALID, 0);
    check("t2_bready",  M_AXI_BREADY,  1);
    tick();
    check("t2_ovalid",  O_VALID, 1);
    check("t2_wdata",   wd_at(0), 32'h1234_5678);
    check("t2_wstrb",   ws_at(0), 4'h3);

    // Queue fills behind a stalled write; overflow requests are dropped
    tick();
    clear_logs();
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    push(32'h3000_0000, 32'hA0A0_A0A0, 4'hF);
    tick();
    exp_addr[0] = 32'h3000_0000;
    exp_data[0] = 32'hA0A0_A0A0;
    exp_strb[0] = 4'hF;
    for (int k = 0; k < 6; k++) begin
      I_VALID = 1'b1;
      I_ADDR  = 32'h4000_0001 + 32'(4 * k);
      I_DATA  = 32'hC0DE_0000 + 32'(k);
      I_STRB  = 4'(k + 1);
      if (k < 4) begin
        exp_addr[k+1] = I_ADDR;
        exp_data[k+1] = I_DATA;
        exp_strb[k+1] = I_STRB;
      end
      check("t3_memwait", MEM_WAIT, (k >= 4) ? 1 : 0);
      tick();
    end
    I_VALID = 1'b0;
    check("t3_memwait_hold", MEM_WAIT, 1);
    check("t3_blocker_addr", M_AXI_AWADDR, 32'h3000_0000);
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    budget = 0;
    while (ov_cnt < 5 && budget < 80) begin
      tick();
      budget++;
    end
    check("t3_ov_count", ov_cnt, 5);
    check("t3_aw_count", aw_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("t3_aw_order", aw_at(i), exp_addr[i]);
      check("t3_w_order",  wd_at(i), exp_data[i]);
      check("t3_w_strb",   ws_at(i), exp_strb[i]);
    end
    check("t3_memwait_clear", MEM_WAIT, 0);

    // Error response reported, following write still proceeds
    tick();
    clear_logs();
    M_AXI_BRESP = 2'b10;
    push(32'h5000_0000, 32'h1111_1111, 4'hF);
    push(32'h5000_0004, 32'h2222_2222, 4'hF);
    budget = 0;
    while (!O_VALID && budget < 20) begin
      tick();
      budget++;
    end
    check("t4_ov_first",   O_VALID, 1);
    check("t4_resp_slverr", O_RESP, 2'b10);
    M_AXI_BRESP = 2'b00;
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!O_VALID && budget < 20);
    check("t4_ov_second",  O_VALID, 1);
    check("t4_resp_okay",  O_RESP,  2'b00);
    check("t4_aw_second",  aw_at(1), 32'h5000_0004);

    // Reset during SEND with two requests queued
    tick();
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    push(32'h6000_0000, 32'h6666_0000, 4'hF);
    push(32'h6000_0004, 32'h6666_0001, 4'hF);
    push(32'h6000_0008, 32'h6666_0002, 4'hF);
    check("t5_pre_awvalid", M_AXI_AWVALID, 1);
    clear_logs();
    ARESETN = 1'b0;
    tick();
    check("t5_awvalid", M_AXI_AWVALID, 0);
    check("t5_wvalid",  M_AXI_WVALID,  0);
    check("t5_bready",  M_AXI_BREADY,  0);
    check("t5_ovalid",  O_VALID,       0);
    check("t5_memwait", MEM_WAIT,      0);
    check("t5_awaddr",  M_AXI_AWADDR,  0);
    ARESETN       = 1'b1;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    repeat (20) tick();
    check("t5_no_writes", aw_log.size(), 0);
    check("t5_no_ov",     ov_cnt,        0);
    push(32'h7000_0000, 32'h7777_7777, 4'hF);
    repeat (6) tick();
    check("t5_fresh_count", aw_log.size(), 1);
    check("t5_fresh_addr",  aw_at(0), 32'h7000_0000);
    check("t5_fresh_ov",    ov_cnt,   1);

    check("aw_stability", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
